// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the FIFO burst controller.
package fifo_ctrl_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_USEDW_W   = 8;
  localparam int DEF_BURST_LEN = 64;
  localparam int FIFO_DEPTH    = 2 ** DEF_USEDW_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CLR   = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_burst_ctrl_sat_cnt.sv
// 16-bit saturating event counter with synchronous clear.
module sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  // Count up on inc, hold at all-ones, clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/fifo_burst_ctrl.sv
// Burst read controller for an external single-clock FIFO (read latency 1).
// Optional statistics counters are built when FIFO_BURST_CTRL_STAT_EN is defined.
module fifo_burst_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int USEDW_W   = DEF_USEDW_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_wrreq,
  output logic               fifo_rdreq,
  output logic               fifo_sclr,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  output logic               m_sop,
  output logic               m_eop,
  input  logic               m_ready,
  input  logic               flush,
  input  logic               clear,
  output logic               busy
`ifdef FIFO_BURST_CTRL_STAT_EN
  ,
  output logic [15:0]        stat_bursts,
  output logic [15:0]        stat_stall
`endif
);

  localparam int LVL_W = USEDW_W + 1;
  localparam logic [LVL_W-1:0] BURST_L = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

  state_t             state_r, state_s;
  logic [LVL_W-1:0]   cnt_r, cnt_s;
  logic [LVL_W-1:0]   level_s;
  logic               flush_pend_r, flush_pend_s;
  logic               clear_pend_r, clear_pend_s;
  logic               rd_s, first_s, last_s;
  logic               rdreq_r, first_r, last_r;
  logic               sclr_r, busy_r;
  logic               m_valid_r, m_sop_r, m_eop_r;
  logic               s_ready_s;

  // usedw wraps to zero when the FIFO holds exactly 2**USEDW_W words.
  assign level_s    = fifo_full ? {1'b1, {USEDW_W{1'b0}}} : {1'b0, fifo_usedw};

  assign s_ready_s  = ~fifo_full & (state_r != ST_CLR);
  assign s_ready    = s_ready_s;
  assign fifo_data  = s_data;
  assign fifo_wrreq = s_valid & s_ready_s;

  assign fifo_rdreq = rdreq_r;
  assign fifo_sclr  = sclr_r;
  assign busy       = busy_r;
  assign m_valid    = m_valid_r;
  assign m_sop      = m_sop_r;
  assign m_eop      = m_eop_r;
  // q is only meaningful on valid beats; gating also keeps m_data at zero in reset.
  assign m_data     = m_valid_r ? fifo_q : {DATA_W{1'b0}};

  // Next-state, read counter and pending-request bookkeeping.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    flush_pend_s = flush_pend_r | flush;
    clear_pend_s = clear_pend_r | clear;
    case (state_r)
      ST_IDLE: begin
        if (clear_pend_r) begin
          state_s      = ST_CLR;
          cnt_s        = {LVL_W{1'b0}};
          clear_pend_s = 1'b0;
          flush_pend_s = 1'b0;
        end else if ((level_s >= BURST_L) && m_ready) begin
          state_s = ST_BURST;
          cnt_s   = BURST_L;
        end else if (flush_pend_r && !fifo_empty && m_ready) begin
          state_s      = ST_FLUSH;
          cnt_s        = level_s;
          flush_pend_s = flush;
        end else if (flush_pend_r && fifo_empty) begin
          flush_pend_s = flush;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST, ST_FLUSH: begin
        if (cnt_r <= ONE_L) begin
          cnt_s = {LVL_W{1'b0}};
          // A clear held back by the burst takes effect right after its last read.
          if (clear_pend_r) begin
            state_s      = ST_CLR;
            clear_pend_s = 1'b0;
            flush_pend_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r - ONE_L;
        end
      end
      ST_CLR: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {LVL_W{1'b0}};
      end
    endcase
  end

  // Read-request markers for the upcoming cycle, delayed later into sop/eop.
  always_comb begin
    rd_s    = (state_s == ST_BURST) || (state_s == ST_FLUSH);
    first_s = rd_s && (state_r == ST_IDLE);
    last_s  = rd_s && (cnt_s == ONE_L);
  end

  // State, counter, pending flags and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {LVL_W{1'b0}};
      flush_pend_r <= 1'b0;
      clear_pend_r <= 1'b0;
      rdreq_r      <= 1'b0;
      first_r      <= 1'b0;
      last_r       <= 1'b0;
      sclr_r       <= 1'b0;
      busy_r       <= 1'b0;
      m_valid_r    <= 1'b0;
      m_sop_r      <= 1'b0;
      m_eop_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      flush_pend_r <= flush_pend_s;
      clear_pend_r <= clear_pend_s;
      rdreq_r      <= rd_s;
      first_r      <= first_s;
      last_r       <= last_s;
      sclr_r       <= (state_s == ST_CLR);
      busy_r       <= (state_s != ST_IDLE);
      m_valid_r    <= rdreq_r;
      m_sop_r      <= first_r;
      m_eop_r      <= last_r;
    end
  end

`ifdef FIFO_BURST_CTRL_STAT_EN
  logic burst_done_s, stall_s, stat_clr_s;

  assign burst_done_s = ((state_r == ST_BURST) || (state_r == ST_FLUSH)) && (cnt_r <= ONE_L);
  assign stall_s      = s_valid & ~s_ready_s;
  assign stat_clr_s   = (state_r == ST_CLR);

  sat_cnt u_bursts (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr_s),
    .inc   (burst_done_s),
    .count (stat_bursts)
  );

  sat_cnt u_stall (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr_s),
    .inc   (stall_s),
    .count (stat_stall)
  );
`endif

endmodule
